rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Write side of the integer register file. Takes results from three producers (ALU, load unit, MUL/DIV),
//  arbitrates round-robin and drives one registered write per cycle (wen/wraddr/wrdata) into the register file.
//  Holds a pending-write scoreboard for long-latency ops. Decode uses it to stall on RAW/WAW hazards.
// PARAMETERS
//  XLEN    32  data width
//  NREG    32  architectural registers (x0 hard-wired zero)
//  RF_AW   32  width of wraddr/query address ports (matches register-file port width; upper bits zero)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  alu_valid    in   1      ALU result valid
//  alu_ready    out  1      ALU result accepted this cycle (valid&ready)
//  alu_rd       in   5      ALU destination
//  alu_data     in   XLEN   ALU result
//  lsu_valid / lsu_ready / lsu_rd / lsu_data     same as ALU, for load results
//  mdu_valid / mdu_ready / mdu_rd / mdu_data     same as ALU, for MUL/DIV results
//  iss_valid    in   1      decode issues an instruction this cycle
//  iss_long     in   1      issued op writes back via LSU or MDU
//  iss_rd       in   5      issued op destination
//  qa1, qa2     in   RF_AW  source addresses being read by decode
//  hazard       out  1      pending[qa1] | pending[qa2] | pending[iss_rd]; combinational
//  wen          out  1      register-file write enable (registered)
//  wraddr       out  RF_AW  register-file write address (registered, zero-extended rd)
//  wrdata       out  XLEN   register-file write data (registered)
//  sb_err       out  1      sticky: issue to an already-pending rd, or long writeback to a non-pending rd
// BEHAVIOUR
//  Reset (async, rst_n=0): wen=0, wraddr=0, wrdata=0, pending=0, sb_err=0, RR pointer=ALU. All readies=0 while in reset.
//  Arbitration
//   - Grant at most one source per cycle, round-robin among valid sources.
//   - Order ALU->LSU->MDU. Pointer advances to the source after the grantee.
//   - ready_x = grant_x. A source holds valid/rd/data stable until ready. Only the granted source sees ready=1.
//  Output stage
//   - Granted result registers into wen/wraddr/wrdata on the next edge: latency 1 cycle from accept to wen.
//   - No grant: wen=0, and wraddr/wrdata hold their last value.
//   - rd==0: accepted (ready=1) but wen stays 0 next cycle; no scoreboard action.
//   - Register-file write-through covers a decode read in the same cycle as wen.
//  Scoreboard (pending[NREG-1:1], pending[0] always 0)
//   - Set: iss_valid & iss_long & iss_rd!=0 -> pending[iss_rd]<=1.
//   - Clear: when wen=1 from LSU/MDU source (source tag registered with data), pending[wraddr]<=0.
//   - ALU writebacks never touch pending.
//   - Set and clear on the same rd in the same cycle: set wins (new producer).
//   - Set on an already-pending rd: set stays 1, sb_err<=1. Decode must have stalled via hazard.
//   - Clear on a non-pending rd: sb_err<=1.
//   - hazard uses the current pending state (not the next one). qa>=NREG or qa==0 contributes 0.
//  No back-pressure from the register file. Throughput is 1 write/cycle. Each source is served at least once every 3 cycles.
// STRUCTURE
//  defines.v: XLEN, REG_NUM, source IDs SRC_ALU=2'd0, SRC_LSU=2'd1, SRC_MDU=2'd2.
//  Sub-module rr_arb3: 3-request round-robin arbiter (req[2:0] -> one-hot gnt, pointer reg, async reset).
//  Top: arbiter, output register with 2-bit source tag, scoreboard vector, hazard compare.
// TESTING
//  1) Reset mid-stream: assert rst_n=0 with pending=0x0000_0F00 and wen=1 -> same cycle wen=0; pending=0, readies=0.
//  2) Single ALU: alu_valid, rd=5, data=0xDEADBEEF at cycle N -> alu_ready@N; wen=1, wraddr=5, wrdata=0xDEADBEEF@N+1.
//  3) All three valid continuously, RR pointer=ALU -> grants ALU,LSU,MDU,ALU...; each ready 1 cycle in 3.
//  4) Issue long rd=7 -> hazard=1 for qa1=7 until LSU writeback of rd=7; hazard=0 in the cycle after wen.
//     Issue long rd=7 again in the same cycle as that wen -> pending[7] stays 1.
//  5) alu_rd=0 with data 0x1234 -> alu_ready=1, wen stays 0; pending unchanged.
//  6) Issue long rd=3 twice without an intervening clear -> sb_err=1 and stays 1 until reset.
//     MDU writeback to non-pending rd=9 -> sb_err=1.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// Shared widths, source identifiers and helpers for the integer register-file write side.
package rf_writeback_pkg;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int RF_AW = 32;
   localparam int RD_W  = 5;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_LSU = 2'd1,
      SRC_MDU = 2'd2
   } src_e;

   // Round-robin successor in the ALU -> LSU -> MDU -> ALU ring.
   function automatic logic [1:0] rr_next(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction
endpackage

// File: rtl/rf_writeback_rr_arb3.sv
// Three-request round-robin arbiter: one-hot grant, pointer moves past the grantee.
module rr_arb3
   import rf_writeback_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] i_req,
   output logic [2:0] o_gnt
);

   logic [1:0] r_ptr;
   logic [1:0] w_c0;
   logic [1:0] w_c1;
   logic [1:0] w_c2;
   logic [1:0] w_sel;
   logic [2:0] w_gnt;

   assign w_c0 = r_ptr;
   assign w_c1 = rr_next(w_c0);
   assign w_c2 = rr_next(w_c1);

   always_comb begin
      w_gnt = 3'b000;
      w_sel = w_c0;
      if (i_req[w_c0]) begin
         w_gnt[w_c0] = 1'b1;
         w_sel       = w_c0;
      end else if (i_req[w_c1]) begin
         w_gnt[w_c1] = 1'b1;
         w_sel       = w_c1;
      end else if (i_req[w_c2]) begin
         w_gnt[w_c2] = 1'b1;
         w_sel       = w_c2;
      end
   end

   // No source may see a grant while the block is held in reset.
   assign o_gnt = w_gnt & {3{rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= SRC_ALU;
      end else if (|w_gnt) begin
         r_ptr <= rr_next(w_sel);
      end
   end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write side: arbitrates ALU/LSU/MDU results into one registered write per cycle
// and tracks long-latency destinations so decode can stall on hazards.
module rf_writeback
   import rf_writeback_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_alu_valid,
   output logic             o_alu_ready,
   input  logic [RD_W-1:0]  i_alu_rd,
   input  logic [XLEN-1:0]  i_alu_data,
   input  logic             i_lsu_valid,
   output logic             o_lsu_ready,
   input  logic [RD_W-1:0]  i_lsu_rd,
   input  logic [XLEN-1:0]  i_lsu_data,
   input  logic             i_mdu_valid,
   output logic             o_mdu_ready,
   input  logic [RD_W-1:0]  i_mdu_rd,
   input  logic [XLEN-1:0]  i_mdu_data,
   input  logic             i_iss_valid,
   input  logic             i_iss_long,
   input  logic [RD_W-1:0]  i_iss_rd,
   input  logic [RF_AW-1:0] i_qa1,
   input  logic [RF_AW-1:0] i_qa2,
   output logic             o_hazard,
   output logic             o_wen,
   output logic [RF_AW-1:0] o_wraddr,
   output logic [XLEN-1:0]  o_wrdata,
   output logic             o_sb_err
);

   logic [2:0]      w_gnt;
   logic [RD_W-1:0] w_sel_rd;
   logic [XLEN-1:0] w_sel_data;
   src_e            w_sel_src;

   logic             r_wen;
   logic [RF_AW-1:0] r_wraddr;
   logic [XLEN-1:0]  r_wrdata;
   src_e             r_src;

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_pending_nxt;
   logic            r_sb_err;
   logic            w_set;
   logic            w_clr;
   logic [RD_W-1:0] w_clr_idx;
   logic            w_err;

   rr_arb3 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req ({i_mdu_valid, i_lsu_valid, i_alu_valid}),
      .o_gnt (w_gnt)
   );

   assign o_alu_ready = w_gnt[SRC_ALU];
   assign o_lsu_ready = w_gnt[SRC_LSU];
   assign o_mdu_ready = w_gnt[SRC_MDU];

   always_comb begin
      w_sel_rd   = i_alu_rd;
      w_sel_data = i_alu_data;
      w_sel_src  = SRC_ALU;
      if (w_gnt[SRC_LSU]) begin
         w_sel_rd   = i_lsu_rd;
         w_sel_data = i_lsu_data;
         w_sel_src  = SRC_LSU;
      end else if (w_gnt[SRC_MDU]) begin
         w_sel_rd   = i_mdu_rd;
         w_sel_data = i_mdu_data;
         w_sel_src  = SRC_MDU;
      end
   end

   // x0 results are consumed but never written; address/data keep their last real write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen    <= 1'b0;
         r_wraddr <= '0;
         r_wrdata <= '0;
         r_src    <= SRC_ALU;
      end else begin
         r_wen <= 1'b0;
         if ((|w_gnt) && (w_sel_rd != '0)) begin
            r_wen    <= 1'b1;
            r_wraddr <= {{(RF_AW-RD_W){1'b0}}, w_sel_rd};
            r_wrdata <= w_sel_data;
            r_src    <= w_sel_src;
         end
      end
   end

   assign o_wen    = r_wen;
   assign o_wraddr = r_wraddr;
   assign o_wrdata = r_wrdata;

   assign w_set     = i_iss_valid & i_iss_long & (i_iss_rd != '0);
   assign w_clr     = r_wen & (r_src != SRC_ALU);
   assign w_clr_idx = r_wraddr[RD_W-1:0];

   // Set is applied after clear so a new producer on the same rd wins.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_clr) begin
         w_pending_nxt[w_clr_idx] = 1'b0;
      end
      if (w_set) begin
         w_pending_nxt[i_iss_rd] = 1'b1;
      end
      w_pending_nxt[0] = 1'b0;
   end

   assign w_err = (w_set && r_pending[i_iss_rd] && !(w_clr && (w_clr_idx == i_iss_rd)))
               || (w_clr && !r_pending[w_clr_idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_sb_err  <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_err) begin
            r_sb_err <= 1'b1;
         end
      end
   end

   assign o_sb_err = r_sb_err;

   function automatic logic pend_at(input logic [NREG-1:0] p, input logic [RF_AW-1:0] a);
      return (a < RF_AW'(NREG)) ? p[a[RD_W-1:0]] : 1'b0;
   endfunction

   assign o_hazard = pend_at(r_pending, i_qa1)
                   | pend_at(r_pending, i_qa2)
                   | r_pending[i_iss_rd];

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, single write, round-robin, scoreboard and error cases.
module tb_rf_writeback;

   logic        clk;
   logic        rst_n;
   logic        alu_valid, lsu_valid, mdu_valid;
   logic        alu_ready, lsu_ready, mdu_ready;
   logic [4:0]  alu_rd, lsu_rd, mdu_rd;
   logic [31:0] alu_data, lsu_data, mdu_data;
   logic        iss_valid, iss_long;
   logic [4:0]  iss_rd;
   logic [31:0] qa1, qa2;
   logic        hazard, wen, sb_err;
   logic [31:0] wraddr, wrdata;

   int checks = 0;
   int errors = 0;

   rf_writeback dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_alu_valid (alu_valid),
      .o_alu_ready (alu_ready),
      .i_alu_rd    (alu_rd),
      .i_alu_data  (alu_data),
      .i_lsu_valid (lsu_valid),
      .o_lsu_ready (lsu_ready),
      .i_lsu_rd    (lsu_rd),
      .i_lsu_data  (lsu_data),
      .i_mdu_valid (mdu_valid),
      .o_mdu_ready (mdu_ready),
      .i_mdu_rd    (mdu_rd),
      .i_mdu_data  (mdu_data),
      .i_iss_valid (iss_valid),
      .i_iss_long  (iss_long),
      .i_iss_rd    (iss_rd),
      .i_qa1       (qa1),
      .i_qa2       (qa2),
      .o_hazard    (hazard),
      .o_wen       (wen),
      .o_wraddr    (wraddr),
      .o_wrdata    (wrdata),
      .o_sb_err    (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] rr_exp;
      rst_n = 1'b0;
      alu_valid = 1'b1; lsu_valid = 1'b0; mdu_valid = 1'b0;
      alu_rd = 5'd0; lsu_rd = 5'd0; mdu_rd = 5'd0;
      alu_data = '0; lsu_data = '0; mdu_data = '0;
      iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
      qa1 = '0; qa2 = '0;
      #12;
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_wraddr", wraddr, 32'd0);
      chk("rst_wrdata", wrdata, 32'd0);
      chk("rst_sb_err", 32'(sb_err), 32'd0);
      alu_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // single ALU write
      tick();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      chk("alu_ready", 32'(alu_ready), 32'd1);
      chk("lsu_ready_idle", 32'(lsu_ready), 32'd0);
      tick();
      alu_valid = 1'b0;
      chk("alu_wen", 32'(wen), 32'd1);
      chk("alu_wraddr", wraddr, 32'd5);
      chk("alu_wrdata", wrdata, 32'hDEADBEEF);
      tick();
      chk("idle_wen", 32'(wen), 32'd0);
      chk("idle_wraddr_hold", wraddr, 32'd5);
      chk("idle_wrdata_hold", wrdata, 32'hDEADBEEF);

      // MDU alone moves the pointer back to ALU
      mdu_valid = 1'b1; mdu_rd = 5'd0;
      #1;
      chk("mdu_alone_ready", 32'(mdu_ready), 32'd1);
      tick();
      mdu_valid = 1'b0;

      // all three continuously valid: ALU, LSU, MDU, ALU, ...
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2;
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hC3;
      #1;
      for (int k = 0; k < 6; k++) begin
         rr_exp = 3'b001 << (k % 3);
         chk($sformatf("rr_gnt_%0d", k), 32'({mdu_ready, lsu_ready, alu_ready}), 32'(rr_exp));
         if (k > 0) begin
            chk($sformatf("rr_wen_%0d", k), 32'(wen), 32'd1);
            chk($sformatf("rr_wraddr_%0d", k), wraddr, 32'(((k - 1) % 3) + 1));
         end
         tick();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
      chk("rr_sb_err", 32'(sb_err), 32'd1);

      // fill pending 8..11, leave wen=1, then reset mid-stream
      for (int r = 8; r < 12; r++) begin
         iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'(r);
         if (r == 11) begin
            alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h0C;
         end
         tick();
      end
      iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0; alu_valid = 1'b0;
      qa1 = 32'd8; qa2 = 32'd11;
      #1;
      chk("pre_rst_wen", 32'(wen), 32'd1);
      chk("pre_rst_hazard", 32'(hazard), 32'd1);
      alu_valid = 1'b1; lsu_valid = 1'b1; mdu_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wen", 32'(wen), 32'd0);
      chk("mid_rst_hazard", 32'(hazard), 32'd0);
      chk("mid_rst_readies", 32'({mdu_ready, lsu_ready, alu_ready}), 32'd0);
      chk("mid_rst_sb_err", 32'(sb_err), 32'd0);
      alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
      qa1 = '0; qa2 = '0;
      @(negedge clk); rst_n = 1'b1;

      // long rd=7: hazard until LSU writeback, reissue in the wen cycle
      tick();
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
      #1;
      chk("haz_pre_issue", 32'(hazard), 32'd0);
      tick();
      iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
      qa1 = 32'd7;
      #1;
      chk("haz_rd7", 32'(hazard), 32'd1);
      qa1 = 32'd39;
      #1;
      chk("haz_qa_out_of_range", 32'(hazard), 32'd0);
      qa1 = 32'd7;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
      #1;
      chk("lsu_ready", 32'(lsu_ready), 32'd1);
      tick();
      lsu_valid = 1'b0;
      chk("lsu_wen", 32'(wen), 32'd1);
      chk("lsu_wraddr", wraddr, 32'd7);
      chk("lsu_wrdata", wrdata, 32'h77);
      chk("haz_during_wen", 32'(hazard), 32'd1);
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
      chk("haz_set_wins", 32'(hazard), 32'd1);
      chk("set_wins_no_err", 32'(sb_err), 32'd0);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h78;
      tick();
      lsu_valid = 1'b0;
      chk("lsu2_wen", 32'(wen), 32'd1);
      chk("haz_wen2", 32'(hazard), 32'd1);
      tick();
      chk("haz_cleared", 32'(hazard), 32'd0);
      chk("clear_no_err", 32'(sb_err), 32'd0);

      // rd=0 accepted but not written
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      #1;
      chk("x0_ready", 32'(alu_ready), 32'd1);
      tick();
      alu_valid = 1'b0;
      chk("x0_wen", 32'(wen), 32'd0);
      chk("x0_hazard", 32'(hazard), 32'd0);
      chk("x0_sb_err", 32'(sb_err), 32'd0);

      // double issue to rd=3
      qa1 = '0;
      iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3;
      tick();
      chk("dbl_first_no_err", 32'(sb_err), 32'd0);
      tick();
      iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
      chk("dbl_err", 32'(sb_err), 32'd1);
      tick();
      tick();
      chk("dbl_err_sticky", 32'(sb_err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("err_rst", 32'(sb_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // MDU writeback to a non-pending rd
      tick();
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
      #1;
      chk("mdu_ready", 32'(mdu_ready), 32'd1);
      tick();
      mdu_valid = 1'b0;
      chk("mdu_wen", 32'(wen), 32'd1);
      chk("mdu_wraddr", wraddr, 32'd9);
      chk("mdu_err_not_yet", 32'(sb_err), 32'd0);
      tick();
      chk("mdu_nonpending_err", 32'(sb_err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
